// File: rtl/display_scan_if.sv
// Bundle of the scan controller's value/handshake and display-side signals.
// The master modport belongs to the value producer; the slave modport belongs to the controller.
interface display_scan_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] digits_in;
    logic                  load;
    logic                  load_ack;
    logic                  lz_en;
    logic [3:0]            number;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_tick;

    modport master (
        output digits_in, load, lz_en,
        input  load_ack, number, an, frame_tick
    );

    modport slave (
        input  digits_in, load, lz_en,
        output load_ack, number, an, frame_tick
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: SHOW/BLANK sequencing, leading-zero
// suppression, and a frame-boundary double buffer so new values never tear mid-frame.
//
// state | meaning
// SHOW  | anode idx lit (unless suppressed) for REFRESH_DIV cycles
// BLANK | all anodes off for BLANK_CYCLES cycles before moving to the next digit
module display_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic          clk,
    input  logic          rst,
    display_scan_if.slave bus
);
    localparam int  MAXC     = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int  CW       = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int  IW       = $clog2(N_DIGITS);
    localparam bit  NO_BLANK = (BLANK_CYCLES == 0);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(NO_BLANK ? 0 : BLANK_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N_DIGITS - 1);

    typedef enum logic {SHOW, BLANK} state_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic [CW-1:0]         cnt;
    logic [4*N_DIGITS-1:0] frame_buf;
    logic [4*N_DIGITS-1:0] pend_buf;
    logic                  pend;
    logic                  load_ack_q;

    logic                  show_last;
    logic                  blank_last;
    logic                  step;
    logic                  boundary;
    logic [IW-1:0]         next_idx;

    always_comb begin
        show_last  = (cnt == SHOW_LAST);
        blank_last = (cnt == BLANK_LAST);
        if (state == SHOW) step = show_last && NO_BLANK;
        else               step = blank_last;
        boundary   = step && (idx == LAST_IDX);
        next_idx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SHOW;
            idx        <= '0;
            cnt        <= '0;
            frame_buf  <= '0;
            pend_buf   <= '0;
            pend       <= 1'b0;
            load_ack_q <= 1'b0;
        end else begin
            load_ack_q <= 1'b0;
            if (bus.load) begin
                pend_buf <= bus.digits_in;
                pend     <= 1'b1;
            end
            case (state)
                SHOW: begin
                    if (show_last) begin
                        cnt <= '0;
                        if (NO_BLANK) idx   <= next_idx;
                        else          state <= BLANK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (blank_last) begin
                        cnt   <= '0;
                        idx   <= next_idx;
                        state <= SHOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= SHOW;
            endcase
            // A request arriving on the boundary cycle itself bypasses pend_buf.
            if (boundary && (bus.load || pend)) begin
                frame_buf  <= bus.load ? bus.digits_in : pend_buf;
                pend       <= 1'b0;
                load_ack_q <= 1'b1;
            end
        end
    end

    logic [3:0]          nib;
    logic [3:0]          mapped;
    logic [N_DIGITS-1:0] lead;
    logic                zero_run;
    logic [N_DIGITS-1:0] an_c;

    always_comb begin
        nib      = '0;
        lead     = '0;
        zero_run = 1'b1;
        an_c     = '1;
        for (int k = 0; k < N_DIGITS; k++)
            if (idx == IW'(k)) nib = frame_buf[4*k +: 4];
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (frame_buf[4*k +: 4] == 4'h0);
            lead[k]  = zero_run;
        end
        // The shared decoder has no glyphs for A-E; show a dash instead.
        mapped = (nib >= 4'hA && nib <= 4'hE) ? 4'hF : nib;
        for (int k = 0; k < N_DIGITS; k++)
            if (!rst && state == SHOW && idx == IW'(k) && !(bus.lz_en && lead[k]))
                an_c[k] = 1'b0;
    end

    assign bus.an         = an_c;
    assign bus.number     = rst ? 4'h0 : mapped;
    assign bus.frame_tick = boundary && !rst;
    assign bus.load_ack   = load_ack_q && !rst;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed, table-driven bench for display_scan_ctrl: one instance with blanking,
// one with BLANK_CYCLES=0, checked against hand-computed cycle checkpoints.
module tb_display_scan_ctrl;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_err    = 0;

    display_scan_if #(.N_DIGITS(4)) ifa ();
    display_scan_if #(.N_DIGITS(4)) ifb ();

    display_scan_ctrl #(.N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ifa.slave)
    );
    display_scan_ctrl #(.N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [3:0] num;
        logic       tick;
        logic       ack;
    } cp_t;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } ev_t;

    cp_t cps[$];
    ev_t evs[$];
    int  ack_cycles[$];

    task automatic chk(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic void cp(input int c, input logic [3:0] a, input logic [3:0] n,
                               input logic t, input logic k);
        cps.push_back('{cyc: c, an: a, num: n, tick: t, ack: k});
    endfunction

    function automatic void ev(input int c, input logic [15:0] v);
        evs.push_back('{cyc: c, val: v});
    endfunction

    initial begin
        logic exp_tick;
        logic exp_ack;
        logic [3:0] exp_an;

        // Frame 0: value 0, load 1234 mid-frame.
        cp(0,   4'b1110, 4'h0, 0, 0); cp(3,   4'b1110, 4'h0, 0, 0);
        cp(4,   4'b1111, 4'h0, 0, 0); cp(6,   4'b1101, 4'h0, 0, 0);
        cp(12,  4'b1011, 4'h0, 0, 0); cp(18,  4'b0111, 4'h0, 0, 0);
        cp(22,  4'b1111, 4'h0, 0, 0); cp(23,  4'b1111, 4'h0, 1, 0);
        cp(24,  4'b1110, 4'h4, 0, 1); cp(25,  4'b1110, 4'h4, 0, 0);
        cp(30,  4'b1101, 4'h3, 0, 0); cp(36,  4'b1011, 4'h2, 0, 0);
        cp(42,  4'b0111, 4'h1, 0, 0); cp(47,  4'b1111, 4'h1, 1, 0);
        // Two requests in one frame: only the latest survives, one ack.
        cp(48,  4'b1110, 4'h4, 0, 0); cp(52,  4'b1111, 4'h4, 0, 0);
        cp(71,  4'b1111, 4'h1, 1, 0); cp(72,  4'b1110, 4'h2, 0, 1);
        cp(78,  4'b1101, 4'h2, 0, 0); cp(84,  4'b1011, 4'h2, 0, 0);
        cp(90,  4'b0111, 4'h2, 0, 0); cp(96,  4'b1110, 4'h2, 0, 0);
        // Load only on the boundary cycle.
        cp(119, 4'b1111, 4'h2, 1, 0); cp(120, 4'b1110, 4'h8, 0, 1);
        cp(126, 4'b1101, 4'h7, 0, 0); cp(132, 4'b1011, 4'h6, 0, 0);
        cp(138, 4'b0111, 4'h5, 0, 0);
        // Code mapping FC09.
        cp(144, 4'b1110, 4'h9, 0, 1); cp(150, 4'b1101, 4'h0, 0, 0);
        cp(156, 4'b1011, 4'hF, 0, 0); cp(162, 4'b0111, 4'hF, 0, 0);
        // Leading-zero suppression: 0050, then 0000, then lz_en dropped.
        cp(168, 4'b1110, 4'h0, 0, 1); cp(174, 4'b1101, 4'h5, 0, 0);
        cp(180, 4'b1111, 4'h0, 0, 0); cp(186, 4'b1111, 4'h0, 0, 0);
        cp(192, 4'b1110, 4'h0, 0, 1); cp(198, 4'b1111, 4'h0, 0, 0);
        cp(204, 4'b1111, 4'h0, 0, 0); cp(210, 4'b1111, 4'h0, 0, 0);
        cp(222, 4'b1111, 4'h0, 0, 0);
        cp(240, 4'b1110, 4'h0, 0, 0); cp(246, 4'b1101, 4'h0, 0, 0);
        cp(252, 4'b1011, 4'h0, 0, 0); cp(258, 4'b0111, 4'h0, 0, 0);
        // 4321 displayed, 0777 pending, reset during digit 2.
        cp(288, 4'b1110, 4'h1, 0, 1); cp(300, 4'b1011, 4'h3, 0, 0);
        cp(301, 4'b1111, 4'h0, 0, 0); cp(302, 4'b1111, 4'h0, 0, 0);
        cp(303, 4'b1110, 4'h0, 0, 0); cp(309, 4'b1101, 4'h0, 0, 0);
        cp(321, 4'b0111, 4'h0, 0, 0); cp(326, 4'b1111, 4'h0, 1, 0);
        cp(327, 4'b1110, 4'h0, 0, 0);

        ev(5, 16'h1234);   ev(51, 16'h1111);  ev(58, 16'h2222);
        ev(119, 16'h5678); ev(130, 16'hFC09); ev(150, 16'h0050);
        ev(175, 16'h0000); ev(264, 16'h4321); ev(290, 16'h0777);

        ack_cycles = '{24, 72, 120, 144, 168, 192, 288};

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.load = 1'b0; ifa.lz_en = 1'b0; ifa.digits_in = '0;
        ifb.load = 1'b0; ifb.lz_en = 1'b0; ifb.digits_in = '0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_an", i, 32'(ifa.an), 32'hF);
        end
        @(posedge clk); #1;

        for (int cyc = 0; cyc <= 330; cyc++) begin
            rst_a     = (cyc == 301 || cyc == 302);
            ifa.load  = 1'b0;
            ifa.lz_en = (cyc >= 168 && cyc < 240);
            foreach (evs[e])
                if (evs[e].cyc == cyc) begin
                    ifa.load      = 1'b1;
                    ifa.digits_in = evs[e].val;
                end
            #1;
            foreach (cps[p])
                if (cps[p].cyc == cyc) begin
                    chk("an",         cyc, 32'(ifa.an),         32'(cps[p].an));
                    chk("number",     cyc, 32'(ifa.number),     32'(cps[p].num));
                    chk("frame_tick", cyc, 32'(ifa.frame_tick), 32'(cps[p].tick));
                    chk("load_ack",   cyc, 32'(ifa.load_ack),   32'(cps[p].ack));
                end
            if (cyc < 301) exp_tick = (cyc % 24 == 23);
            else           exp_tick = (cyc >= 303) && ((cyc - 303) % 24 == 23);
            exp_ack = 1'b0;
            foreach (ack_cycles[j])
                if (ack_cycles[j] == cyc) exp_ack = 1'b1;
            chk("tick_period", cyc, 32'(ifa.frame_tick), 32'(exp_tick));
            chk("ack_once",    cyc, 32'(ifa.load_ack),   32'(exp_ack));
            @(posedge clk); #1;
        end
        rst_a = 1'b1;

        rst_b = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            exp_an = 4'b1111;
            exp_an[(c / 4) % 4] = 1'b0;
            chk("nb_an",   c, 32'(ifb.an),         32'(exp_an));
            chk("nb_tick", c, 32'(ifb.frame_tick), 32'(c % 16 == 15));
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one BCD-to-segment decoder. Each cycle it selects one digit, presents that digit's 4-bit code on `number` to the shared decoder, and drives that digit's anode enable. It also inserts anti-ghosting blank intervals, optionally suppresses leading zeros, and double-buffers the displayed value so updates only take effect at frame boundaries (no tearing).

Parameters:
- N_DIGITS, 4: number of multiplexed digits; minimum 2.
- REFRESH_DIV, 50000: clock cycles each digit is lit (SHOW phase); minimum 1.
- BLANK_CYCLES, 500: clock cycles all anodes are off between digits (BLANK phase); 0 means BLANK is skipped.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- digits_in, input, 4*N_DIGITS: new value; nibble k is digit k, and digit 0 is least significant.
- load, input, 1: request to adopt digits_in; level-sampled every cycle.
- load_ack, output, 1: one-cycle pulse when a requested value becomes the displayed value.
- lz_en, input, 1: leading-zero suppression enable; sampled live.
- number, output, 4: code sent to the shared decoder.
- an, output, N_DIGITS: anode enables, active-low, one-hot-low or all-ones.
- frame_tick, output, 1: one-cycle pulse on the last cycle of each frame.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- While rst=1 and on the first edge after it:
  - state=SHOW, idx=0, cnt=0.
  - frame_buf=0 and pend=0.
  - load_ack=0 and frame_tick=0.
  - an is forced to all ones while rst=1. number=0.
- Reset mid-operation discards any pending load and issues no ack.
- State machine (SHOW / BLANK):
  - SHOW: cnt counts 0..REFRESH_DIV-1. At cnt=REFRESH_DIV-1, cnt clears and the FSM goes to BLANK. If BLANK_CYCLES=0, it instead advances idx and stays in SHOW.
  - BLANK: cnt counts 0..BLANK_CYCLES-1. At the last count, cnt clears, idx advances, and the FSM returns to SHOW.
  - idx wraps from N_DIGITS-1 to 0.
- Frame boundary is the cycle on which idx wraps from N_DIGITS-1.
  - frame_tick=1 on exactly that cycle.
  - Frame length is N_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
- Outputs are combinational decodes of registered state only; no extra pipeline stage.
  - SHOW: an[idx]=0 and all other an bits are 1. number = mapped nibble idx of frame_buf.
  - BLANK: an is all ones. number holds the SHOW value.
- Code mapping:
  - Nibbles 0-9 and F pass through unchanged.
  - Nibbles A-E are replaced by 4'hF (dash), because the decoder does not define them.
- Leading-zero suppression, when lz_en=1:
  - Digit k is suppressed if frame_buf nibbles N_DIGITS-1 down to k are all 0 and k != 0.
  - A suppressed digit keeps its anode high during its SHOW slot. number still carries 0.
  - Digit 0 is never suppressed.
- Load buffering:
  - Any cycle with load=1 copies digits_in into pend_buf and sets pend. The latest request wins.
  - At the frame-boundary edge, if load=1 or pend=1: frame_buf takes digits_in if load=1 that cycle, otherwise pend_buf. pend clears.
  - load_ack pulses for one cycle, namely the first cycle frame_buf shows the new value.
  - Multiple requests within one frame produce exactly one ack.
- Arithmetic and counter widths:
  - cnt is wide enough for max(REFRESH_DIV, BLANK_CYCLES)-1.
  - idx is $clog2(N_DIGITS) bits.
  - No counter ever exceeds its terminal value.

Test Plan:
Parameters N_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2 unless noted.
1. Reset: hold rst for 3 cycles, then release.
   - Required: an=1111 during reset.
   - Then an=1110 and number=0 for 4 cycles, then an=1111 for 2 cycles, then an=1101.
   - frame_tick every 24 cycles.
2. Load timing: pulse load with digits_in=16'h1234 at cycle 5.
   - Required: display unchanged until the boundary at cycle 23.
   - load_ack=1 at cycle 24.
   - Then number = 4, 3, 2, 1 on an = 1110, 1101, 1011, 0111 respectively.
3. Repeated loads: load 16'h1111 at cycle 3, then 16'h2222 at cycle 10.
   - Required: single load_ack; the displayed digits are all 2.
   - Also: load=1 only on the boundary cycle with 16'h5678 is adopted immediately, with ack the next cycle.
4. Leading-zero suppression: lz_en=1, value 16'h0050.
   - Required: digits 3 and 2 keep an high in their slots; digit 1 shows 5; digit 0 shows 0.
   - Value 16'h0000: only digit 0 is lit.
   - Dropping lz_en lights all four digits.
5. Code mapping: value 16'hFC09.
   - Required: number sequence 9, 0, F, F, i.e. C is mapped to F and F passes through.
6. Reset mid-operation and no-blank mode:
   - Assert rst during digit 2 SHOW with a load pending. Required: an=1111, no load_ack, frame_buf=0 after release.
   - With BLANK_CYCLES=0: an is never all ones outside reset, and the frame is 16 cycles.
